// File: rtl/dm_banked_ctrl.sv
// Word-organised data memory behind a req/ready handshake with WAIT wait states,
// sub-word access, and a post-reset clearing sweep. Define DM_TRACE_EN for store/error tracing.
module dm_banked_ctrl #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        WE,
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {CLEAR, IDLE, WAITING, RESP} state_t;

    state_t             state;
    state_t             next_state;
    logic [ADDR_W-1:0]  clr_idx;
    logic [3:0]         wait_cnt;
    logic               cap_we;
    logic [2:0]         cap_mode;
    logic [ADDR_W+1:0]  cap_addr;
    logic [31:0]        cap_wd;
    logic [31:0]        rd_q;
    logic               err_q;
    logic [31:0]        mem [0:DEPTH-1];

    logic               accept;
    logic               enter_resp;
    logic [ADDR_W-1:0]  word_idx;
    logic [31:0]        cur_word;
    logic [4:0]         lane_lsb;
    logic [4:0]         half_lsb;
    logic [15:0]        half_sel;
    logic [7:0]         byte_sel;
    logic               misaligned;
    logic               access_err;
    logic [31:0]        load_val;
    logic [31:0]        store_word;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign accept     = (state == IDLE || state == RESP) && req;
    assign enter_resp = (state == WAITING) && (wait_cnt == 4'd0);

    assign word_idx = cap_addr[ADDR_W+1:2];
    assign cur_word = mem[word_idx];
    assign lane_lsb = {cap_addr[1:0], 3'b000};
    assign half_lsb = {cap_addr[1], 4'b0000};
    assign half_sel = cur_word[half_lsb +: 16];
    assign byte_sel = cur_word[lane_lsb +: 8];

    always_comb begin
        misaligned = 1'b0;
        case (cap_mode)
            3'd0:       misaligned = (cap_addr[1:0] != 2'b00);
            3'd1, 3'd2: misaligned = cap_addr[0];
            default:    misaligned = 1'b0;
        endcase
    end

    assign access_err = misaligned || (cap_mode > 3'd4);

    // Load extension and read-modify-write merge of the selected lanes.
    always_comb begin
        load_val   = '0;
        store_word = cur_word;
        case (cap_mode)
            3'd0: begin
                load_val   = cur_word;
                store_word = cap_wd;
            end
            3'd1, 3'd2: begin
                load_val = {{16{half_sel[15] & cap_mode[1]}}, half_sel};
                store_word[half_lsb +: 16] = cap_wd[15:0];
            end
            3'd3, 3'd4: begin
                load_val = {{24{byte_sel[7] & cap_mode[2]}}, byte_sel};
                store_word[lane_lsb +: 8] = cap_wd[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (&clr_idx) next_state = IDLE;
            IDLE:    if (req) next_state = WAITING;
            WAITING: if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = req ? WAITING : IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // The counter starts at WAIT and the access fires one edge after it reaches zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            wait_cnt <= '0;
            cap_we   <= 1'b0;
            cap_mode <= '0;
            cap_addr <= '0;
            cap_wd   <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == CLEAR)
                clr_idx <= clr_idx + ADDR_W'(1);
            if (accept) begin
                cap_we   <= WE;
                cap_mode <= mode;
                cap_addr <= addr[ADDR_W+1:0];
                cap_wd   <= WD;
                wait_cnt <= 4'(WAIT);
            end else if (state == WAITING && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q <= access_err;
                rd_q  <= (access_err || cap_we) ? 32'd0 : load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR)
                mem[clr_idx] <= 32'd0;
            else if (enter_resp && cap_we && !access_err)
                mem[word_idx] <= store_word;
        end
    end

`ifdef DM_TRACE_EN
    always @(posedge clk) begin
        if (reset && enter_resp) begin
            if (access_err)
                $display("%0t: DM err @%h", $time, 32'(cap_addr));
            else if (cap_we)
                $display("%0t: *%h <= %h", $time, 32'({word_idx, 2'b00}), store_word);
        end
    end
`else
`endif

    assign ready = (state == RESP);
    assign RD    = (state == RESP) ? rd_q : 32'd0;
    assign err   = (state == RESP) ? err_q : 1'b0;
    assign busy  = (state == CLEAR) || (state == WAITING);

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Self-checking bench for dm_banked_ctrl: two instances (WAIT=0 and WAIT=3) checked
// against a byte-array reference model with directed and randomized accesses.
module tb_dm_banked_ctrl;
    localparam int AW    = 4;
    localparam int BYTES = 4 << AW;

    typedef struct {
        bit          w;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;

    logic        clk = 1'b0;
    logic        reset [2];
    logic        req   [2];
    logic        we    [2];
    logic [2:0]  mode  [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    int checks = 0;
    int errors = 0;
    byte unsigned ref_mem [2][BYTES];

    always #5 clk = ~clk;

    dm_banked_ctrl #(.ADDR_W(AW), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .WE(we[0]), .mode(mode[0]),
        .addr(addr[0]), .WD(wd[0]), .RD(rd[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0])
    );

    dm_banked_ctrl #(.ADDR_W(AW), .WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .WE(we[1]), .mode(mode[1]),
        .addr(addr[1]), .WD(wd[1]), .RD(rd[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic op_t mk(input bit w, input logic [2:0] m, input logic [31:0] a,
                               input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
        op_t o;
        o.w = w; o.m = m; o.a = a; o.data = data; o.exp_rd = exp_rd; o.exp_err = exp_err;
        return o;
    endfunction

    // Reference: memory as a flat byte array, accesses as size/alignment arithmetic.
    task automatic model_access(input int d, input bit w, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] data, output logic [31:0] exp_rd, output logic exp_err);
        int size;
        int base;
        longint unsigned v;
        exp_rd  = 32'd0;
        exp_err = 1'b0;
        case (m)
            3'd0:       size = 4;
            3'd1, 3'd2: size = 2;
            3'd3, 3'd4: size = 1;
            default:    size = 0;
        endcase
        if (size == 0 || (int'(a[1:0]) % size) != 0) begin
            exp_err = 1'b1;
            return;
        end
        base = int'(a[AW+1:0]);
        if (w) begin
            for (int i = 0; i < size; i++) ref_mem[d][base+i] = data[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[d][base+i]) << (8*i));
            if ((m == 3'd2 || m == 3'd4) && v[8*size-1]) v = v | ({64{1'b1}} << (8*size));
            exp_rd = v[31:0];
        end
    endtask

    task automatic clear_model(input int d);
        for (int i = 0; i < BYTES; i++) ref_mem[d][i] = 8'd0;
    endtask

    task automatic do_access(input int d, input bit w, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] data, output logic [31:0] got_rd, output logic got_err,
                             output int lat, output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; mode[d] = m; addr[d] = a; wd[d] = data;
        @(negedge clk);
        req[d] = 1'b0; we[d] = 1'($urandom); mode[d] = 3'($urandom);
        addr[d] = $urandom; wd[d] = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (ready[d] !== 1'b1 && lat < 60) begin
            if (busy[d] !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        got_rd  = rd[d];
        got_err = err[d];
        @(negedge clk);
        pulse_ok = (ready[d] === 1'b0);
    endtask

    task automatic test_reset;
        int cnt [2];
        bit saw_ready;
        logic [31:0] g_rd;
        logic g_err;
        int lat;
        bit b_ok, p_ok;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; mode[d] = '0; addr[d] = '0; wd[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rd[d] !== 32'd0 || busy[d] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d: ready=%b err=%b RD=%h busy=%b, expected 0 0 00000000 1",
                         d, ready[d], err[d], rd[d], busy[d]);
            end
        end
        reset[0] = 1'b1; reset[1] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; mode[0] = 3'd0; addr[0] = 32'h3C; wd[0] = 32'hFFFFFFFF;
        cnt[0] = 0; cnt[1] = 0;
        saw_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (busy[d] === 1'b1) cnt[d]++;
                if (ready[d] === 1'b1) saw_ready = 1'b1;
            end
            if (busy[0] !== 1'b1) req[0] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt[d] !== 16) begin
                errors++;
                $display("[TB] FAIL sweep_length dut%0d: busy cycles=%0d, expected 16", d, cnt[d]);
            end
            clear_model(d);
        end
        checks++;
        if (saw_ready) begin
            errors++;
            $display("[TB] FAIL sweep_ready: ready=1 seen during sweep, expected 0");
        end
        do_access(0, 1'b0, 3'd0, 32'h3C, 32'd0, g_rd, g_err, lat, b_ok, p_ok);
        checks++;
        if (g_rd !== 32'd0 || g_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_sweep_load: RD=%h err=%b, expected 00000000 0", g_rd, g_err);
        end
    endtask

    task automatic run_ops_word(input op_t ops[$], input string tag);
        logic [31:0] g_rd, e_rd;
        logic g_err, e_err;
        int lat;
        bit b_ok, p_ok;
        foreach (ops[i]) begin
            model_access(0, ops[i].w, ops[i].m, ops[i].a, ops[i].data, e_rd, e_err);
            do_access(0, ops[i].w, ops[i].m, ops[i].a, ops[i].data, g_rd, g_err, lat, b_ok, p_ok);
            checks++;
            if (g_rd !== ops[i].exp_rd || g_err !== ops[i].exp_err || lat !== 1 || !b_ok || !p_ok) begin
                errors++;
                $display("[TB] FAIL %s[%0d]: RD=%h err=%b lat=%0d busy_ok=%b pulse_ok=%b, expected RD=%h err=%b lat=1 1 1",
                         tag, i, g_rd, g_err, lat, b_ok, p_ok, ops[i].exp_rd, ops[i].exp_err);
            end
        end
    endtask

    task automatic test_word;
        op_t ops[$];
        ops.push_back(mk(1, 3'd0, 32'h04, 32'd100, 32'd0, 1'b0));
        ops.push_back(mk(0, 3'd0, 32'h04, 32'd0, 32'd100, 1'b0));
        ops.push_back(mk(1, 3'd0, 32'h0C, 32'd200, 32'd0, 1'b0));
        ops.push_back(mk(0, 3'd0, 32'h0C, 32'd0, 32'd200, 1'b0));
        run_ops_word(ops, "word");
    endtask

    task automatic test_lanes;
        op_t ops[$];
        ops.push_back(mk(1, 3'd0, 32'h08, 32'h11223344, 32'd0, 1'b0));
        ops.push_back(mk(1, 3'd3, 32'h09, 32'h555555AB, 32'd0, 1'b0));
        ops.push_back(mk(0, 3'd4, 32'h09, 32'd0, 32'hFFFFFFAB, 1'b0));
        ops.push_back(mk(0, 3'd3, 32'h09, 32'd0, 32'h000000AB, 1'b0));
        ops.push_back(mk(0, 3'd0, 32'h08, 32'd0, 32'h1122AB44, 1'b0));
        ops.push_back(mk(1, 3'd1, 32'h12, 32'hAAAA8001, 32'd0, 1'b0));
        ops.push_back(mk(0, 3'd2, 32'h12, 32'd0, 32'hFFFF8001, 1'b0));
        ops.push_back(mk(0, 3'd1, 32'h12, 32'd0, 32'h00008001, 1'b0));
        ops.push_back(mk(0, 3'd0, 32'h10, 32'd0, 32'h80010000, 1'b0));
        run_ops_word(ops, "lanes");
    endtask

    task automatic test_errors;
        op_t ops[$];
        ops.push_back(mk(1, 3'd0, 32'h06, 32'hDEADBEEF, 32'd0, 1'b1));
        ops.push_back(mk(0, 3'd0, 32'h04, 32'd0, 32'd100, 1'b0));
        ops.push_back(mk(0, 3'd6, 32'h04, 32'd0, 32'd0, 1'b1));
        ops.push_back(mk(1, 3'd7, 32'h00, 32'hCAFEF00D, 32'd0, 1'b1));
        ops.push_back(mk(0, 3'd0, 32'h00, 32'd0, 32'd0, 1'b0));
        ops.push_back(mk(0, 3'd2, 32'h11, 32'd0, 32'd0, 1'b1));
        run_ops_word(ops, "errors");
    endtask

    task automatic test_random;
        logic [31:0] g_rd, e_rd, a, data;
        logic g_err, e_err;
        logic [2:0] m;
        bit w;
        int lat, d;
        bit b_ok, p_ok;
        for (int i = 0; i < 60; i++) begin
            d = i % 2;
            w = 1'($urandom);
            m = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            data = $urandom;
            model_access(d, w, m, a, data, e_rd, e_err);
            do_access(d, w, m, a, data, g_rd, g_err, lat, b_ok, p_ok);
            checks++;
            if (g_rd !== e_rd || g_err !== e_err || lat !== wait_of(d) + 1 || !b_ok || !p_ok) begin
                errors++;
                $display("[TB] FAIL random[%0d] dut%0d we=%b mode=%0d addr=%h: RD=%h err=%b lat=%0d busy_ok=%b pulse_ok=%b, expected RD=%h err=%b lat=%0d",
                         i, d, w, m, a, g_rd, g_err, lat, b_ok, p_ok, e_rd, e_err, wait_of(d) + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] g_rd, e_rd;
        logic g_err, e_err;
        int lat;
        bit b_ok, p_ok, busy_ok;
        int pos[$];
        model_access(1, 1'b1, 3'd0, 32'h24, 32'h0BADF00D, e_rd, e_err);
        do_access(1, 1'b1, 3'd0, 32'h24, 32'h0BADF00D, g_rd, g_err, lat, b_ok, p_ok);
        model_access(1, 1'b0, 3'd0, 32'h24, 32'd0, e_rd, e_err);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; mode[1] = 3'd0; addr[1] = 32'h24;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (pos.size() < 3 && busy[1] !== !ready[1]) busy_ok = 1'b0;
            if (ready[1] === 1'b1) begin
                pos.push_back(i);
                checks++;
                if (rd[1] !== e_rd || err[1] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_data[%0d]: RD=%h err=%b, expected %h 0", pos.size(), rd[1], err[1], e_rd);
                end
                if (pos.size() == 3) req[1] = 1'b0;
            end
        end
        checks++;
        if (pos.size() != 3 || pos[0] != 5 || pos[1] != 10 || pos[2] != 15) begin
            errors++;
            $display("[TB] FAIL b2b_timing: %0d pulses, first=%0d, expected 3 pulses at 5,10,15",
                     pos.size(), (pos.size() > 0) ? pos[0] : -1);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("[TB] FAIL b2b_busy: busy not 1 in wait cycles or not 0 in response cycles");
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] g_rd;
        logic g_err;
        int lat, cnt;
        bit b_ok, p_ok, bad;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; mode[1] = 3'd0; addr[1] = 32'h20; wd[1] = 32'h0000DEAD;
        @(negedge clk);
        req[1] = 1'b0;
        reset[1] = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready[1] !== 1'b0 || busy[1] !== 1'b1 || rd[1] !== 32'd0 || err[1] !== 1'b0) bad = 1'b1;
        end
        reset[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ready[1] !== 1'b0) bad = 1'b1;
        end
        reset[1] = 1'b0;
        @(negedge clk);
        reset[1] = 1'b1;
        clear_model(1);
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            if (busy[1] === 1'b1) cnt++;
            if (ready[1] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: response or nonzero output seen after reset mid-access");
        end
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("[TB] FAIL sweep_restart: busy cycles=%0d, expected 16", cnt);
        end
        do_access(1, 1'b0, 3'd0, 32'h20, 32'd0, g_rd, g_err, lat, b_ok, p_ok);
        checks++;
        if (g_rd !== 32'd0 || g_err !== 1'b0 || lat !== 4) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: RD=%h err=%b lat=%0d, expected 00000000 0 4", g_rd, g_err, lat);
        end
    endtask

    initial begin
        test_reset;
        test_word;
        test_lanes;
        test_errors;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
